// File: rtl/ib_link_pkg.sv
// Shared types and helpers for the IB link sequencer.
// No logic of its own; no latency or backpressure.
// TALK_TOKEN is the receiver-side talk byte, kept here for reference.
package ib_link_pkg;

    typedef enum logic [0:0] {R_IDLE, R_ACK} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_DRAIN, T_GRANT, T_ACK} talk_state_t;

    localparam logic [7:0] TALK_TOKEN = 8'hFE;

    // Bits needed to hold a countdown starting at TALK_TIMEOUT.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ib_link_ctrl_if.sv
// Receiver, command-stream and reply-grant signals of the IB link sequencer.
// Wires only; no latency.
// The slave modport is the sequencer side; the master modport is its environment.
interface ib_link_ctrl_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ack_n;
    logic             rx_talk;
    logic             rx_talk_ack;
    logic [7:0]       cmd_data;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             tx_pending;
    logic             tx_grant;
    logic             tx_done;
    logic             tx_timeout;

    modport slave (
        input  rx_data, rx_valid, rx_talk, cmd_ready, tx_pending, tx_done,
        output rx_ack_n, rx_talk_ack, cmd_data, cmd_valid, fifo_level, tx_grant, tx_timeout
    );

    modport master (
        output rx_data, rx_valid, rx_talk, cmd_ready, tx_pending, tx_done,
        input  rx_ack_n, rx_talk_ack, cmd_data, cmd_valid, fifo_level, tx_grant, tx_timeout
    );

endinterface

// File: rtl/ib_byte_fifo.sv
// Synchronous byte FIFO, DEPTH a power of 2, first-word-fall-through head.
// Latency: push visible on dout/empty one cycle later.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
module ib_byte_fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic        pop,
    output logic [7:0]  dout,
    output logic        empty,
    output logic        full,
    output logic [AW:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!nrst) !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (!nrst) !(push && full && !pop));

endmodule

// File: rtl/ib_link_ctrl.sv
// IB link sequencer: drains receiver bytes into a command FIFO and services the talk token (optional IB_LINK_STATS_EN counters).
// Latency: rx_valid->rx_ack_n 1 cycle, push->cmd_valid 1 cycle, idle talk->rx_talk_ack 2 cycles.
// Backpressure: full FIFO withholds the receiver ack; cmd stream is valid/ready.
module ib_link_ctrl
    import ib_link_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int TALK_TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          nrst,
    ib_link_ctrl_if.slave bus
`ifdef IB_LINK_STATS_EN
    ,
    output logic [15:0]   stat_bytes,
    output logic [7:0]    stat_talks,
    output logic [7:0]    stat_timeouts
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TW    = timer_width(TALK_TIMEOUT);

    rx_state_t        rx_state;
    talk_state_t      talk_state;
    logic             rx_ack_n_q;
    logic             talk_ack_q;
    logic             grant_q;
    logic             timeout_q;
    logic [TW-1:0]    timer;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic [7:0]       head;
    logic [LVL_W-1:0] level;

    assign push = (rx_state == R_IDLE) && bus.rx_valid && !full;
    assign pop  = !empty && bus.cmd_ready;

    ib_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .din   (bus.rx_data),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    assign bus.rx_ack_n    = rx_ack_n_q;
    assign bus.rx_talk_ack = talk_ack_q;
    assign bus.tx_grant    = grant_q;
    assign bus.tx_timeout  = timeout_q;
    assign bus.cmd_data    = head;
    assign bus.cmd_valid   = !empty;
    assign bus.fifo_level  = level;

    // One push per handshake: the byte is taken on entry to R_ACK only.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_state   <= R_IDLE;
            rx_ack_n_q <= 1'b1;
        end else begin
            case (rx_state)
                R_IDLE: if (push) begin
                    rx_ack_n_q <= 1'b0;
                    rx_state   <= R_ACK;
                end
                R_ACK: if (!bus.rx_valid) begin
                    rx_ack_n_q <= 1'b1;
                    rx_state   <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Replies wait for every queued command to be consumed first.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            talk_state <= T_IDLE;
            talk_ack_q <= 1'b0;
            grant_q    <= 1'b0;
            timeout_q  <= 1'b0;
            timer      <= '0;
        end else begin
            talk_ack_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (talk_state)
                T_IDLE: if (bus.rx_talk) talk_state <= T_DRAIN;
                T_DRAIN: if (empty && !pop) begin
                    if (bus.tx_pending) begin
                        grant_q    <= 1'b1;
                        timer      <= TW'(TALK_TIMEOUT);
                        talk_state <= T_GRANT;
                    end else begin
                        talk_ack_q <= 1'b1;
                        talk_state <= T_ACK;
                    end
                end
                T_GRANT: begin
                    // tx_done wins over an expiring timer.
                    if (bus.tx_done || timer == '0) begin
                        grant_q    <= 1'b0;
                        timeout_q  <= !bus.tx_done;
                        talk_ack_q <= 1'b1;
                        talk_state <= T_ACK;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                T_ACK:   talk_state <= T_IDLE;
                default: talk_state <= T_IDLE;
            endcase
        end
    end

`ifdef IB_LINK_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stat_bytes    <= '0;
            stat_talks    <= '0;
            stat_timeouts <= '0;
        end else begin
            if (push)       stat_bytes    <= stat_bytes + 16'd1;
            if (talk_ack_q) stat_talks    <= stat_talks + 8'd1;
            if (timeout_q)  stat_timeouts <= stat_timeouts + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ib_link_ctrl.sv
// Bench for ib_link_ctrl: receiver/consumer/reply models with a byte scoreboard.
// dut_a uses the default timeout, dut_b a timeout of 8; both see identical stimulus.
module tb_ib_link_ctrl;
    import ib_link_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_talk = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       tx_pending = 1'b0;
    logic       tx_done = 1'b0;
    bit         sel = 1'b0;

    logic       ack_n, talk_ack, c_valid, grant, tmo;
    logic [7:0] c_data;
    logic [4:0] level;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    ib_link_ctrl_if #(.FIFO_DEPTH(16)) bus_a ();
    ib_link_ctrl_if #(.FIFO_DEPTH(16)) bus_b ();

    assign bus_a.rx_data    = rx_data;
    assign bus_a.rx_valid   = rx_valid;
    assign bus_a.rx_talk    = rx_talk;
    assign bus_a.cmd_ready  = cmd_ready;
    assign bus_a.tx_pending = tx_pending;
    assign bus_a.tx_done    = tx_done;
    assign bus_b.rx_data    = rx_data;
    assign bus_b.rx_valid   = rx_valid;
    assign bus_b.rx_talk    = rx_talk;
    assign bus_b.cmd_ready  = cmd_ready;
    assign bus_b.tx_pending = tx_pending;
    assign bus_b.tx_done    = tx_done;

`ifdef IB_LINK_STATS_EN
    logic [15:0] sb_a, sb_b;
    logic [7:0]  st_a, st_b, so_a, so_b;
`endif

    ib_link_ctrl #(.FIFO_DEPTH(16), .TALK_TIMEOUT(4095)) dut_a (
        .clk(clk), .nrst(nrst), .bus(bus_a)
`ifdef IB_LINK_STATS_EN
        , .stat_bytes(sb_a), .stat_talks(st_a), .stat_timeouts(so_a)
`endif
    );

    ib_link_ctrl #(.FIFO_DEPTH(16), .TALK_TIMEOUT(8)) dut_b (
        .clk(clk), .nrst(nrst), .bus(bus_b)
`ifdef IB_LINK_STATS_EN
        , .stat_bytes(sb_b), .stat_talks(st_b), .stat_timeouts(so_b)
`endif
    );

    always_comb begin
        ack_n    = sel ? bus_b.rx_ack_n    : bus_a.rx_ack_n;
        talk_ack = sel ? bus_b.rx_talk_ack : bus_a.rx_talk_ack;
        c_valid  = sel ? bus_b.cmd_valid   : bus_a.cmd_valid;
        c_data   = sel ? bus_b.cmd_data    : bus_a.cmd_data;
        level    = sel ? bus_b.fifo_level  : bus_a.fifo_level;
        grant    = sel ? bus_b.tx_grant    : bus_a.tx_grant;
        tmo      = sel ? bus_b.tx_timeout  : bus_a.tx_timeout;
    end

    // Consumer monitor: inputs only change 1 time unit after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (nrst && c_valid && cmd_ready) got_q.push_back(c_data);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0; rx_talk = 1'b0; cmd_ready = 1'b0; tx_pending = 1'b0; tx_done = 1'b0;
        nrst = 1'b0;
        tick(); tick();
        nrst = 1'b1;
        tick();
        exp_q.delete();
        got_q.delete();
    endtask

    // Receiver model: one full valid/ack handshake, valid held 'hold' cycles past the ack.
    task automatic send_byte(input logic [7:0] b, input int hold, output int lat, output logic vld);
        rx_data = b; rx_valid = 1'b1;
        exp_q.push_back(b);
        lat = 0;
        do begin tick(); lat++; end while (ack_n !== 1'b0 && lat < 100);
        vld = c_valid;
        tests_run++;
        if (ack_n !== 1'b0) begin
            tests_failed++; $display("FAIL ack_wait byte=%02h rx_ack_n=%b required 0", b, ack_n);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            tests_run++;
            if (ack_n !== 1'b0) begin
                tests_failed++; $display("FAIL ack_hold byte=%02h rx_ack_n=%b required 0", b, ack_n);
            end
        end
        rx_valid = 1'b0;
        tick();
        tests_run++;
        if (ack_n !== 1'b1) begin
            tests_failed++; $display("FAIL ack_release byte=%02h rx_ack_n=%b required 1", b, ack_n);
        end
    endtask

    task automatic test_reset();
        #2 nrst = 1'b0;
        #1;
        tests_run++;
        if ({ack_n, talk_ack, grant, tmo, c_valid} !== 5'b10000 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset ack_n,talk_ack,grant,tmo,valid=%b level=%0d required 10000 level 0",
                     {ack_n, talk_ack, grant, tmo, c_valid}, level);
        end
        do_reset();
        tests_run++;
        if ({ack_n, talk_ack, grant, tmo, c_valid} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_release outputs=%b required 10000", {ack_n, talk_ack, grant, tmo, c_valid});
        end
    endtask

    task automatic test_basic();
        int lat; logic vld; int n; logic [7:0] e, g;
        sel = 1'b0; do_reset(); cmd_ready = 1'b1;
        send_byte(8'h12, 2, lat, vld);
        tests_run++;
        if (lat !== 1 || vld !== 1'b1) begin
            tests_failed++; $display("FAIL basic_latency ack_cycles=%0d cmd_valid=%b required 1 and 1", lat, vld);
        end
        send_byte(8'h34, 0, lat, vld);
        send_byte(8'h56, 3, lat, vld);
        n = 0;
        while (got_q.size() < 3 && n < 50) begin tick(); n++; end
        repeat (4) tick();
        tests_run++;
        if (got_q.size() !== 3) begin
            tests_failed++; $display("FAIL basic_count got=%0d required 3", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL basic_data got=%02h required %02h", g, e); end
        end
    endtask

    task automatic test_full();
        int lat; logic vld; int n; int early; logic [7:0] e, g;
        sel = 1'b0; do_reset(); cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 0, lat, vld);
        tests_run++;
        if (level !== 5'd16) begin tests_failed++; $display("FAIL full_level got=%0d required 16", level); end
        rx_data = 8'h90; rx_valid = 1'b1; exp_q.push_back(8'h90);
        early = 0;
        repeat (6) begin tick(); if (ack_n !== 1'b1) early++; end
        tests_run++;
        if (early !== 0 || level !== 5'd16) begin
            tests_failed++; $display("FAIL full_stall acks=%0d level=%0d required 0 acks level 16", early, level);
        end
        cmd_ready = 1'b1;
        n = 0;
        while (ack_n !== 1'b0 && n < 20) begin tick(); n++; end
        tests_run++;
        if (ack_n !== 1'b0) begin tests_failed++; $display("FAIL full_late_ack rx_ack_n=%b required 0", ack_n); end
        rx_valid = 1'b0;
        n = 0;
        while (got_q.size() < 17 && n < 60) begin tick(); n++; end
        repeat (3) tick();
        tests_run++;
        if (got_q.size() !== 17) begin
            tests_failed++; $display("FAIL full_count got=%0d required 17", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL full_data got=%02h required %02h", g, e); end
        end
    endtask

    task automatic test_talk_idle();
        int acks; int grants;
        sel = 1'b0; do_reset();
        rx_talk = 1'b1;
        grants = 0;
        tick(); if (grant) grants++;
        tests_run++;
        if (talk_ack !== 1'b0) begin tests_failed++; $display("FAIL talk_ack_early got=%b required 0", talk_ack); end
        tick(); if (grant) grants++;
        tests_run++;
        if (talk_ack !== 1'b1) begin tests_failed++; $display("FAIL talk_ack_latency got=%b required 1", talk_ack); end
        acks = 1; rx_talk = 1'b0;
        repeat (8) begin tick(); if (talk_ack) acks++; if (grant) grants++; end
        tests_run++;
        if (acks !== 1 || grants !== 0) begin
            tests_failed++; $display("FAIL talk_idle acks=%0d grants=%0d required 1 and 0", acks, grants);
        end
    endtask

    task automatic test_talk_drain();
        int lat; logic vld; int early; int lvl0; int gtick; int drop; int extra; logic [7:0] e, g;
        sel = 1'b0; do_reset(); cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 0, lat, vld);
        rx_talk = 1'b1; tx_pending = 1'b1;
        early = 0;
        repeat (4) begin tick(); if (grant) early++; end
        cmd_ready = 1'b1;
        lvl0 = -1; gtick = -1;
        for (int n = 1; n <= 60 && gtick < 0; n++) begin
            tick();
            if (level === 5'd0 && lvl0 < 0) lvl0 = n;
            if (grant === 1'b1) gtick = n;
        end
        tests_run++;
        if (early !== 0 || gtick < 0 || gtick !== lvl0 + 1) begin
            tests_failed++;
            $display("FAIL drain_grant early=%0d grant_cycle=%0d empty_cycle=%0d required 0 and empty+1", early, gtick, lvl0);
        end
        drop = 0;
        for (int k = 0; k < 9; k++) begin tick(); if (grant !== 1'b1) drop++; end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tests_run++;
        if (drop !== 0 || grant !== 1'b0 || talk_ack !== 1'b1 || tmo !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_done drops=%0d grant=%b ack=%b tmo=%b required 0,0,1,0", drop, grant, talk_ack, tmo);
        end
        rx_talk = 1'b0; tx_pending = 1'b0;
        extra = 0;
        repeat (6) begin tick(); if (talk_ack || tmo || grant) extra++; end
        tests_run++;
        if (extra !== 0) begin tests_failed++; $display("FAIL drain_after extra_pulses=%0d required 0", extra); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL drain_data got=%02h required %02h", g, e); end
        end
    endtask

    task automatic test_timeout(input bit with_done);
        int n; int cnt; int tmos; int acks;
        sel = 1'b1; do_reset();
        rx_talk = 1'b1; tx_pending = 1'b1;
        n = 0;
        while (grant !== 1'b1 && n < 20) begin tick(); n++; end
        cnt = 0; tmos = 0; acks = 0;
        for (int i = 0; i < 30; i++) begin
            if (grant) cnt++;
            if (tmo) tmos++;
            if (talk_ack) begin acks++; rx_talk = 1'b0; end
            tx_done = with_done && (cnt == 9) && grant;
            tick();
        end
        tx_pending = 1'b0; rx_talk = 1'b0; tx_done = 1'b0;
        tests_run++;
        if (cnt !== 9 || acks !== 1 || tmos !== (with_done ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL timeout done=%0d grant_cycles=%0d acks=%0d timeouts=%0d required 9,1,%0d",
                     with_done, cnt, acks, tmos, with_done ? 0 : 1);
        end
    endtask

    task automatic test_midreset();
        int lat; logic vld; int n;
        sel = 1'b0; do_reset(); cmd_ready = 1'b0;
        send_byte(8'h5A, 0, lat, vld);
        rx_data = 8'h6B; rx_valid = 1'b1;
        tick();
        tests_run++;
        if (ack_n !== 1'b0) begin tests_failed++; $display("FAIL mid_pre_ack rx_ack_n=%b required 0", ack_n); end
        #2 nrst = 1'b0;
        #1;
        tests_run++;
        if (ack_n !== 1'b1 || level !== 5'd0 || c_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_rx_reset ack_n=%b level=%0d valid=%b required 1,0,0", ack_n, level, c_valid);
        end
        tick(); rx_valid = 1'b0; nrst = 1'b1; tick();
        exp_q.delete(); got_q.delete();
        cmd_ready = 1'b1;
        send_byte(8'h77, 0, lat, vld);
        repeat (3) tick();
        tests_run++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h77) begin
            tests_failed++; $display("FAIL mid_recover count=%0d required 1 byte 77", got_q.size());
        end
`ifdef IB_LINK_STATS_EN
        tests_run++;
        if (sb_a !== 16'd1) begin tests_failed++; $display("FAIL stat_bytes got=%0d required 1", sb_a); end
`endif
        rx_talk = 1'b1; tx_pending = 1'b1;
        n = 0;
        while (grant !== 1'b1 && n < 20) begin tick(); n++; end
        tick(); tick();
        tests_run++;
        if (grant !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_grant grant=%b required 1", grant); end
        #2 nrst = 1'b0;
        #1;
        tests_run++;
        if (grant !== 1'b0 || talk_ack !== 1'b0 || tmo !== 1'b0 || ack_n !== 1'b1) begin
            tests_failed++; $display("FAIL mid_grant_reset grant=%b ack=%b tmo=%b ack_n=%b required 0,0,0,1", grant, talk_ack, tmo, ack_n);
        end
`ifdef IB_LINK_STATS_EN
        tests_run++;
        if (sb_a !== 16'd0 || st_a !== 8'd0 || so_a !== 8'd0) begin
            tests_failed++; $display("FAIL stat_reset bytes=%0d talks=%0d timeouts=%0d required 0", sb_a, st_a, so_a);
        end
`endif
        tick(); rx_talk = 1'b0; tx_pending = 1'b0; nrst = 1'b1; tick();
        rx_talk = 1'b1;
        tick(); tick();
        tests_run++;
        if (talk_ack !== 1'b1 || grant !== 1'b0) begin
            tests_failed++; $display("FAIL mid_talk_recover ack=%b grant=%b required 1,0", talk_ack, grant);
        end
        rx_talk = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_talk_idle();
        test_talk_drain();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
